elevator_scheduler: RTL
=======================

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 4, SHALL set the number of served floors (fixed 4 in this revision; floor index width 2).
REQ-002 Parameter DWELL_CYCLES, default 100_000_000, SHALL set the door-open dwell in clk cycles (1 s at 100 MHz).
REQ-003 clk  input  1  SHALL be the single system clock; all logic on its rising edge.
REQ-004 reset_p  input  1  SHALL be the synchronous, active-high reset.
REQ-005 call_pe  input  4  SHALL carry one-cycle call pulses per floor, already debounced and edge-detected.
REQ-006 move_busy  input  1  SHALL be high while the stepper sequencer is executing a move.
REQ-007 move_done  input  1  SHALL be a one-cycle pulse from the sequencer marking move completion.
REQ-008 move_start  output  1  SHALL be a one-cycle move command pulse.
REQ-009 move_dir  output  1  SHALL give move direction, 0 = up, 1 = down; valid with move_start.
REQ-010 move_dist  output  2  SHALL give the floor count to travel (1..3); valid with move_start.
REQ-011 cur_floor  output  2  SHALL give the last floor reached.
REQ-012 pending  output  4  SHALL expose the latched call mask.
REQ-013 door_open  output  1  SHALL be high only in state DOOR.
REQ-014 floor_led  output  4  SHALL be one-hot of cur_floor.

Function
REQ-015 States SHALL be IDLE, DISPATCH, MOVING, DOOR; all outputs registered.
REQ-016 Every cycle pending[i] SHALL be set by call_pe[i], except a call for cur_floor in IDLE or DOOR, which is not latched.
REQ-017 IDLE: call_pe[cur_floor] -> DOOR; else pending != 0 -> DISPATCH; else stay.
REQ-018 DISPATCH: with move_busy high, stay and assert nothing; pending[cur_floor] set (defensive) -> clear it, -> DOOR.
REQ-019 DISPATCH target (SCAN): keep current sweep direction if any pending floor lies that way, else reverse; target = nearest pending floor in the chosen direction.
REQ-020 DISPATCH with move_busy low: pulse move_start, drive move_dir and move_dist = |target - cur_floor|, register target, -> MOVING.
REQ-021 Call-to-move latency: call_pe in IDLE at cycle n, move_busy low -> move_start high in cycle n+2 exactly.
REQ-022 MOVING: on move_done, cur_floor <= target, pending[target] cleared, -> DOOR; calls en route are latched, not served until next DISPATCH.
REQ-023 move_done and call_pe[target] in the same cycle: call counts as served, pending[target] ends 0.
REQ-024 move_done outside MOVING SHALL be ignored; no state change.
REQ-025 DOOR: dwell counter loads DWELL_CYCLES-1 on entry, decrements to 0, then -> IDLE; door_open high exactly DWELL_CYCLES cycles absent restarts.
REQ-026 call_pe[cur_floor] during DOOR SHALL reload the dwell counter.
REQ-027 Sweep direction reg SHALL persist across IDLE; resets to up.

Reset
REQ-028 reset_p SHALL force IDLE, cur_floor 0, pending 0, direction up, dwell 0, move_start 0, move_dir 0, move_dist 0, door_open 0, floor_led 4'b0001, and clear calls arriving that cycle.
REQ-029 Reset mid-MOVING SHALL abandon the move; a following move_done is ignored; floor re-syncs to 0 by definition.

Structure
REQ-030 Shared package elevator_pkg SHALL hold the state enum, FLOOR_W = 2, and DIR_UP/DIR_DOWN constants.
REQ-031 The dwell countdown SHALL be sub-module door_timer (load, expire pulse); scheduler FSM and target selection stay in elevator_scheduler.

Verification (NUM_FLOORS 4, DWELL_CYCLES 10)
REQ-032 Reset, call_pe=4'b0100 -> move_start at +2 cycles, move_dir 0, move_dist 2; move_done -> cur_floor 2, door_open 10 cycles, pending 0.
REQ-033 At floor 1 sweeping up, pending 4'b1001 -> first move to 3 (dir 0, dist 2), then to 0 (dir 1, dist 3).
REQ-034 call_pe[cur_floor] during DOOR at dwell cycle 7 -> door_open extends to 17 cycles total.
REQ-035 move_busy held high in DISPATCH for 5 cycles -> no move_start until busy falls, then one pulse only.
REQ-036 move_done coincident with call_pe[target] -> pending[target]=0, DOOR entered; stray move_done in IDLE -> no change.
REQ-037 reset_p asserted mid-MOVING with pending 4'b1010 -> all outputs at reset values next cycle, pending 0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator scheduler and its door timer.
package elevator_pkg;
  localparam int N_FLOORS = 4;
  localparam int FLOOR_W  = 2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_MOVING   = 2'd2,
    ST_DOOR     = 2'd3
  } state_t;

  function automatic logic [N_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    return N_FLOORS'(1) << f;
  endfunction
endpackage

// File: rtl/door_timer.sv
// Door dwell countdown: load restarts a DWELL_CYCLES window, expire pulses in its last cycle.
module door_timer #(
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic load,
  output logic expire
);
  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             running;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= CNT_W'(DWELL_CYCLES - 1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  // A reload in the final cycle wins over expiry so the door stays open.
  assign expire = running && (cnt == '0) && !load;
endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-style elevator scheduler: latches floor calls, issues moves to the stepper
// sequencer, and holds the door open for a dwell period at each served floor.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 4,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [NUM_FLOORS-1:0] call_pe,
  input  logic                  move_busy,
  input  logic                  move_done,
  output logic                  move_start,
  output logic                  move_dir,
  output logic [FLOOR_W-1:0]    move_dist,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] floor_led,
  output state_t                state_dbg
);
  // Sequencer handshake: move_start is a one-cycle command issued only while
  // move_busy is low; move_done is a one-cycle completion pulse honoured only in MOVING.
  state_t                state, state_n;
  logic [NUM_FLOORS-1:0] pending_n, cur_hot, latch_mask;
  logic [FLOOR_W-1:0]    cur_floor_n, target, target_n, move_dist_n;
  logic                  sweep_dir, sweep_dir_n, move_start_n, move_dir_n;
  logic                  call_cur, timer_load, timer_expire;

  logic                  has_up, has_down, go_down;
  logic [FLOOR_W-1:0]    up_tgt, down_tgt, sel_tgt, sel_dist;

  door_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_door_timer (
    .clk    (clk),
    .reset_p(reset_p),
    .load   (timer_load),
    .expire (timer_expire)
  );

  // Nearest pending floor above and below the current floor.
  always_comb begin
    has_up   = 1'b0;
    has_down = 1'b0;
    up_tgt   = cur_floor;
    down_tgt = cur_floor;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > int'(cur_floor)) && !has_up) begin
        has_up = 1'b1;
        up_tgt = FLOOR_W'(i);
      end
      if (pending[i] && (i < int'(cur_floor))) begin
        has_down = 1'b1;
        down_tgt = FLOOR_W'(i);
      end
    end
    go_down  = (sweep_dir == DIR_DOWN) ? has_down : !has_up;
    sel_tgt  = go_down ? down_tgt : up_tgt;
    sel_dist = go_down ? (cur_floor - down_tgt) : (up_tgt - cur_floor);
  end

  always_comb begin
    state_n      = state;
    cur_floor_n  = cur_floor;
    sweep_dir_n  = sweep_dir;
    target_n     = target;
    move_start_n = 1'b0;
    move_dir_n   = move_dir;
    move_dist_n  = move_dist;
    timer_load   = 1'b0;
    cur_hot      = floor_onehot(cur_floor);
    call_cur     = |(call_pe & cur_hot);
    // A call for the floor the car is parked at is served by the door, not latched.
    latch_mask   = ((state == ST_IDLE) || (state == ST_DOOR)) ? ~cur_hot : '1;
    pending_n    = pending | (call_pe & latch_mask);

    case (state)
      ST_IDLE: begin
        if (call_cur) begin
          state_n    = ST_DOOR;
          timer_load = 1'b1;
        end else if (pending_n != '0) begin
          state_n = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (move_busy) begin
          state_n = ST_DISPATCH;
        end else if ((pending & cur_hot) != '0) begin
          pending_n  = pending_n & ~cur_hot;
          state_n    = ST_DOOR;
          timer_load = 1'b1;
        end else if (pending == '0) begin
          state_n = ST_IDLE;
        end else begin
          move_start_n = 1'b1;
          move_dir_n   = go_down ? DIR_DOWN : DIR_UP;
          move_dist_n  = sel_dist;
          sweep_dir_n  = go_down ? DIR_DOWN : DIR_UP;
          target_n     = sel_tgt;
          state_n      = ST_MOVING;
        end
      end
      ST_MOVING: begin
        if (move_done) begin
          cur_floor_n = target;
          pending_n   = pending_n & ~floor_onehot(target);
          state_n     = ST_DOOR;
          timer_load  = 1'b1;
        end
      end
      ST_DOOR: begin
        if (call_cur)          timer_load = 1'b1;
        else if (timer_expire) state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state      <= ST_IDLE;
      cur_floor  <= '0;
      pending    <= '0;
      sweep_dir  <= DIR_UP;
      target     <= '0;
      move_start <= 1'b0;
      move_dir   <= 1'b0;
      move_dist  <= '0;
      door_open  <= 1'b0;
      floor_led  <= floor_onehot('0);
    end else begin
      state      <= state_n;
      cur_floor  <= cur_floor_n;
      pending    <= pending_n;
      sweep_dir  <= sweep_dir_n;
      target     <= target_n;
      move_start <= move_start_n;
      move_dir   <= move_dir_n;
      move_dist  <= move_dist_n;
      door_open  <= (state_n == ST_DOOR);
      floor_led  <= floor_onehot(cur_floor_n);
    end
  end

  assign state_dbg = state;
endmodule
